// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, device ACK; both lines driven open-drain via OE pins.
module ps2_host_tx #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 750_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout,
    output logic [2:0] state_dbg
);

    // Handshake: a command is taken on any rising clk edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE and requests made while busy are dropped, not queued.

    if (CLK_HZ <= 0 || INHIBIT_CYCLES < 2 || FILTER_CYCLES < 1 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1_048_575) begin : g_bad_params
        $error("ps2_host_tx: parameter out of range");
    end

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(FILTER_CYCLES - 1);
    localparam logic [19:0]   TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_SHIFT   = 3'd3,
        S_ACK     = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Bit 0 is the PS/2 clock, bit 1 is the PS/2 data line.
    logic [1:0]    pads;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [FW-1:0] fcnt [2];
    logic          kclk_prev;
    logic          clk_fall;

    assign pads = {kdata_in, kclk_in};

    // Filtered level only follows the synchronized pad after FILTER_CYCLES
    // consecutive samples disagree with it; shorter glitches are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            level   <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1 <= pads;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == F_LAST) begin
                    level[i] <= sync2[i];
                    fcnt[i]  <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign clk_fall = kclk_prev & ~level[0];

    state_t        state, state_d;
    logic [IW-1:0] icnt, icnt_d;
    logic [19:0]   tcnt, tcnt_d;
    logic [3:0]    n, n_d;
    logic [9:0]    sh, sh_d;
    logic          kclk_oe_q, kclk_oe_d;
    logic          kdata_oe_q, kdata_oe_d;
    logic          done_q, done_d;
    logic          ack_q, ack_d;
    logic          to_q, to_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            icnt       <= '0;
            tcnt       <= '0;
            n          <= '0;
            sh         <= '0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            to_q       <= 1'b0;
            kclk_prev  <= 1'b1;
        end else begin
            state      <= state_d;
            icnt       <= icnt_d;
            tcnt       <= tcnt_d;
            n          <= n_d;
            sh         <= sh_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            to_q       <= to_d;
            kclk_prev  <= level[0];
        end
    end

    always_comb begin
        state_d    = state;
        icnt_d     = icnt;
        tcnt_d     = tcnt;
        n_d        = n;
        sh_d       = sh;
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;
        done_d     = 1'b0;
        ack_d      = ack_q;
        to_d       = to_q;

        case (state)
            S_IDLE: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                if (tx_valid) begin
                    // Frame bits in send order from bit 0: data LSB first, odd parity, stop.
                    sh_d      = {1'b1, ~^tx_data, tx_data};
                    icnt_d    = '0;
                    ack_d     = 1'b0;
                    to_d      = 1'b0;
                    kclk_oe_d = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                kclk_oe_d = 1'b1;
                icnt_d    = icnt + IW'(1);
                // Start bit goes out one cycle before the clock is released.
                if (icnt == INH_PRE) begin
                    kdata_oe_d = 1'b1;
                end
                if (icnt == INH_LAST) begin
                    kclk_oe_d  = 1'b0;
                    kdata_oe_d = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b1;
                tcnt_d     = 20'd1;
                n_d        = 4'd0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                tcnt_d = tcnt + 20'd1;
                if (clk_fall) begin
                    kdata_oe_d = ~sh[0];
                    sh_d       = {1'b0, sh[9:1]};
                    n_d        = n + 4'd1;
                    if (n == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                tcnt_d = tcnt + 20'd1;
                if (clk_fall) begin
                    ack_d   = ~level[1];
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                tcnt_d = tcnt + 20'd1;
                if (level[0] && level[1]) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        // tcnt counts cycles since the clock was released; the abort wins over any edge.
        if ((state == S_SHIFT || state == S_ACK || state == S_RELEASE) && tcnt == TO_LAST) begin
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            done_d     = 1'b1;
            ack_d      = 1'b0;
            to_d       = 1'b1;
            state_d    = S_DONE;
        end
    end

    assign tx_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign kclk_oe   = kclk_oe_q;
    assign kdata_oe  = kdata_oe_q;
    assign done      = done_q;
    assign ack_ok    = ack_q;
    assign timeout   = to_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard on an open-drain bus decodes
// each frame and is compared with a frame computed from the command byte.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int FILT = 8;
    localparam int TO   = 2500;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, kclk_oe, kdata_oe, busy, done, ack_ok, timeout;
    logic [2:0] state_dbg;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch_low = 1'b0;
    logic kclk_bus, kdata_bus;

    assign kclk_bus  = ~(kclk_oe | dev_clk_low | glitch_low);
    assign kdata_bus = ~(kdata_oe | dev_data_low);

    int checks = 0;
    int passed = 0;

    ps2_host_tx #(
        .CLK_HZ(50_000_000), .INHIBIT_CYCLES(INH),
        .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .kclk_in(kclk_bus), .kdata_in(kdata_bus),
        .kclk_oe(kclk_oe), .kdata_oe(kdata_oe), .busy(busy), .done(done),
        .ack_ok(ack_ok), .timeout(timeout), .state_dbg(state_dbg)
    );

    always #10 clk = ~clk;

    int   done_cnt = 0;
    int   inh_cnt = 0;
    logic last_ack = 1'b0;
    logic last_to = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_ack = ack_ok;
            last_to  = timeout;
        end
        if (kclk_oe === 1'b1) inh_cnt = inh_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference frame as the device should see it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Device side: wait for request-to-send, then clock out `pulses` cycles,
    // sampling the data line just after each rising edge.
    task automatic device_frame(input bit do_ack, input bit glitch, input int pulses,
                                output logic [10:0] bits, output bit ok);
        int w;
        bits = '1;
        ok = 1'b0;
        w = 0;
        @(negedge clk);
        while (!(kclk_bus === 1'b1 && kdata_bus === 1'b0) && w < INH + 200) begin
            @(negedge clk);
            w++;
        end
        if (!(kclk_bus === 1'b1 && kdata_bus === 1'b0)) begin
            checks++;
            $display("FAIL rts_wait: no request-to-send after %0d cycles", w);
            return;
        end
        bits[0] = kdata_bus;
        ok = 1'b1;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= pulses; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            @(negedge clk);
            if (k <= 10) bits[k] = kdata_bus;
            if (k == 10 && do_ack) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            if (glitch && k == 4) begin
                repeat (10) @(negedge clk);
                glitch_low = 1'b1;
                repeat (3) @(negedge clk);
                glitch_low = 1'b0;
                repeat (HALF - 14) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
        end
    endtask

    task automatic send_and_check(input logic [7:0] b, input bit do_ack, input bit glitch,
                                  input string name);
        int d0, i0, w;
        logic [10:0] bits, exp;
        bit ok;
        exp = expected_frame(b);
        d0 = done_cnt;
        i0 = inh_cnt;
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || kclk_oe !== 1'b1 || tx_ready !== 1'b0)
            $display("FAIL %s_start: busy=%b kclk_oe=%b tx_ready=%b, required 1 1 0", name, busy, kclk_oe, tx_ready);
        else passed++;
        device_frame(do_ack, glitch, 11, bits, ok);
        w = 0;
        while (done_cnt == d0 && w < 2 * TO) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bits !== exp) $display("FAIL %s_frame: device saw %b, required %b (byte %h)", name, bits, exp, b);
        else passed++;
        checks++;
        if (done_cnt - d0 != 1) $display("FAIL %s_done: %0d done cycles, required 1", name, done_cnt - d0);
        else passed++;
        checks++;
        if (last_ack !== do_ack || last_to !== 1'b0)
            $display("FAIL %s_result: ack_ok=%b timeout=%b at done, required %b 0", name, last_ack, last_to, do_ack);
        else passed++;
        checks++;
        if (ack_ok !== do_ack || timeout !== 1'b0)
            $display("FAIL %s_hold: ack_ok=%b timeout=%b after done, required %b 0", name, ack_ok, timeout, do_ack);
        else passed++;
        checks++;
        if (inh_cnt - i0 != INH) $display("FAIL %s_inhibit: kclk_oe high %0d cycles, required %0d", name, inh_cnt - i0, INH);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (kclk_oe !== 0 || kdata_oe !== 0 || tx_ready !== 1 || busy !== 0 || done !== 0 || ack_ok !== 0 || timeout !== 0)
            $display("FAIL reset_values: oe=%b%b ready=%b busy=%b done=%b ack=%b to=%b, required 00 1 0 0 0 0",
                     kclk_oe, kdata_oe, tx_ready, busy, done, ack_ok, timeout);
        else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_ready !== 1 || busy !== 0 || kclk_oe !== 0)
            $display("FAIL idle_after_reset: ready=%b busy=%b kclk_oe=%b, required 1 0 0", tx_ready, busy, kclk_oe);
        else passed++;
    endtask

    task automatic test_timeout();
        int w, k;
        @(negedge clk);
        tx_data = 8'($urandom_range(0, 255));
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        w = 0;
        while (kclk_oe !== 1'b0 && w < INH + 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (kdata_oe !== 1'b1 || kclk_oe !== 1'b0)
            $display("FAIL to_req: kclk_oe=%b kdata_oe=%b at clock release, required 0 1", kclk_oe, kdata_oe);
        else passed++;
        k = 0;
        while (done !== 1'b1 && k < TO + 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != TO) $display("FAIL to_latency: done %0d cycles after release, required %0d", k, TO);
        else passed++;
        checks++;
        if (timeout !== 1 || ack_ok !== 0 || kclk_oe !== 0 || kdata_oe !== 0 || tx_ready !== 0)
            $display("FAIL to_flags: to=%b ack=%b oe=%b%b ready=%b, required 1 0 00 0",
                     timeout, ack_ok, kclk_oe, kdata_oe, tx_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1 || timeout !== 1)
            $display("FAIL to_after: tx_ready=%b timeout=%b, required 1 1", tx_ready, timeout);
        else passed++;
    endtask

    task automatic test_reset_mid_shift();
        logic [10:0] bits;
        bit ok;
        int d0;
        @(negedge clk);
        tx_data = 8'($urandom_range(0, 255));
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        device_frame(1'b1, 1'b0, 5, bits, ok);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (kclk_oe !== 0 || kdata_oe !== 0 || tx_ready !== 1 || busy !== 0 || done !== 0 || ack_ok !== 0 || timeout !== 0)
            $display("FAIL midreset_values: oe=%b%b ready=%b busy=%b done=%b ack=%b to=%b, required 00 1 0 0 0 0",
                     kclk_oe, kdata_oe, tx_ready, busy, done, ack_ok, timeout);
        else passed++;
        repeat (200) @(negedge clk);
        checks++;
        if (done_cnt != d0) $display("FAIL midreset_done: %0d done cycles after reset, required 0", done_cnt - d0);
        else passed++;
        send_and_check(8'hF4, 1'b1, 1'b0, "after_reset_f4");
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic [10:0] bits_a, bits_b;
        bit ok_a, ok_b;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        if (b == a) b = ~a;
        @(negedge clk);
        tx_data = a;
        tx_valid = 1'b1;
        @(negedge clk);
        fork
            device_frame(1'b1, 1'b0, 11, bits_a, ok_a);
            begin
                int w;
                w = 0;
                while (done !== 1'b1 && w < 3 * TO) begin
                    tx_data = 8'($urandom_range(0, 255));
                    @(negedge clk);
                    w++;
                end
                tx_data = b;
                @(negedge clk);
                checks++;
                if (tx_ready !== 1'b1) $display("FAIL b2b_ready: tx_ready=%b after done, required 1", tx_ready);
                else passed++;
                @(negedge clk);
                checks++;
                if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b after second handshake, required 1", busy);
                else passed++;
                tx_valid = 1'b0;
            end
        join
        device_frame(1'b1, 1'b0, 11, bits_b, ok_b);
        repeat (20) @(negedge clk);
        checks++;
        if (bits_a !== expected_frame(a)) $display("FAIL b2b_first: device saw %b, required %b", bits_a, expected_frame(a));
        else passed++;
        checks++;
        if (bits_b !== expected_frame(b)) $display("FAIL b2b_second: device saw %b, required %b", bits_b, expected_frame(b));
        else passed++;
        checks++;
        if (busy !== 1'b0 || ack_ok !== 1'b1) $display("FAIL b2b_end: busy=%b ack_ok=%b, required 0 1", busy, ack_ok);
        else passed++;
    endtask

    initial begin
        test_reset();
        send_and_check(8'hED, 1'b1, 1'b0, "cmd_ed");
        send_and_check(8'h00, 1'b1, 1'b0, "cmd_00");
        send_and_check(8'h01, 1'b1, 1'b0, "cmd_01");
        send_and_check(8'($urandom_range(0, 255)), 1'b0, 1'b0, "no_ack");
        for (int i = 0; i < 4; i++) send_and_check(8'($urandom_range(0, 255)), 1'b1, 1'b0, "random");
        send_and_check(8'($urandom_range(0, 255)), 1'b1, 1'b1, "glitch");
        test_timeout();
        test_reset_mid_shift();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
